// File: rtl/mfe_led7seg_74hc595_scan.sv
// Multiplexed 7-segment scanner driving cascaded 74HC595s: double-buffered frame,
// runtime tick divider, polarity options and per-digit OE brightness.
module mfe_led7seg_74hc595_scan #(
    parameter int DIG_NUM        = 8,
    parameter int SEG_NUM        = 8,
    parameter int DIV_WIDTH      = 8,
    parameter int BRIGHT_WIDTH   = 4,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SEG_NUM*DIG_NUM-1:0] dat,
    input  logic                       vld,
    input  logic                       en,
    input  logic [DIV_WIDTH-1:0]       div_cfg,
    input  logic [BRIGHT_WIDTH-1:0]    bright,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       sclk,
    output logic                       rclk,
    output logic                       dio,
    output logic                       oe_n
);
    localparam int CHA_WIDTH = SEG_NUM + DIG_NUM;
    localparam int DIG_W     = $clog2(DIG_NUM);
    localparam int BIT_W     = $clog2(CHA_WIDTH);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, HOLD} state_t;
    state_t state, state_nxt;

    logic [DIG_NUM-1:0][SEG_NUM-1:0] shadow, active, frame_src;
    logic                    pending;
    logic [DIG_W-1:0]        dig_idx;
    logic [CHA_WIDTH-1:0]    shreg, word;
    logic [BIT_W-1:0]        bit_cnt;
    logic [DIV_WIDTH-1:0]    div_q, div_cnt;
    logic [BRIGHT_WIDTH-1:0] bright_q, hold_cnt;
    logic [SEG_NUM-1:0]      seg_w;
    logic [DIG_NUM-1:0]      pos_w;
    logic tick, bit_last, hold_last, dig_last, swap;

    assign tick      = (div_cnt == div_q);
    assign bit_last  = (bit_cnt == BIT_W'(CHA_WIDTH - 1));
    assign hold_last = (hold_cnt == '1);
    assign dig_last  = (dig_idx == DIG_W'(DIG_NUM - 1));

    // Frame swap happens only at the digit-0 load; a write landing in that very
    // cycle bypasses the shadow so it is shown without a frame of delay.
    always_comb begin
        swap      = (state == LOAD) && (dig_idx == '0) && (vld || pending);
        frame_src = active;
        if (swap) frame_src = vld ? dat : shadow;
        seg_w = frame_src[dig_idx];
        if (SEG_ACTIVE_LOW != 0) seg_w = ~seg_w;
        pos_w = DIG_NUM'(1) << dig_idx;
        if (DIG_ACTIVE_LOW != 0) pos_w = ~pos_w;
        word = {seg_w, pos_w};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b1;
        frame_done = 1'b0;
        sclk       = 1'b0;
        rclk       = 1'b0;
        dio        = 1'b0;
        oe_n       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (en) state_nxt = LOAD;
            end
            LOAD: state_nxt = SHIFT_LO;
            SHIFT_LO: begin
                dio = shreg[CHA_WIDTH-1];
                if (tick) state_nxt = SHIFT_HI;
            end
            SHIFT_HI: begin
                sclk = 1'b1;
                dio  = shreg[CHA_WIDTH-1];
                if (tick) state_nxt = bit_last ? LATCH : SHIFT_LO;
            end
            LATCH: begin
                rclk = 1'b1;
                if (tick) state_nxt = HOLD;
            end
            HOLD: begin
                oe_n = (hold_cnt >= bright_q);
                if (tick && hold_last) begin
                    frame_done = dig_last;
                    state_nxt  = en ? LOAD : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow   <= '0;
            active   <= '0;
            pending  <= 1'b0;
            dig_idx  <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            div_q    <= '0;
            div_cnt  <= '0;
            bright_q <= '0;
            hold_cnt <= '0;
        end else begin
            if (vld) begin
                shadow  <= dat;
                pending <= 1'b1;
            end
            if (state == LOAD)      div_cnt <= '0;
            else if (state != IDLE) div_cnt <= tick ? '0 : div_cnt + 1'b1;
            case (state)
                LOAD: begin
                    shreg    <= word;
                    div_q    <= div_cfg;
                    bit_cnt  <= '0;
                    hold_cnt <= '0;
                    if (swap) begin
                        active  <= frame_src;
                        pending <= 1'b0;
                    end
                end
                SHIFT_HI: if (tick && !bit_last) begin
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
                LATCH: bright_q <= bright;
                HOLD: if (tick) begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_last) dig_idx <= dig_last ? '0 : dig_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mfe_led7seg_74hc595_scan.sv
// Self-checking bench: reconstructs latched 595 words from the pins and compares
// them with a frame/digit model; timing checked in clock cycles.
module tb_mfe_led7seg_74hc595_scan;
    logic clk = 1'b0;
    logic rst;
    logic [63:0] dat, dat2;
    logic vld, en, vld2, en2;
    logic [7:0] div_cfg, div_cfg2;
    logic [3:0] bright, bright2;
    logic busy, frame_done, sclk, rclk, dio, oe_n;
    logic busy2, frame_done2, sclk2, rclk2, dio2, oe_n2;

    int total = 0, bad = 0, cyc = 0;
    logic [63:0] cur;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mfe_led7seg_74hc595_scan dut (
        .clk(clk), .rst(rst), .dat(dat), .vld(vld), .en(en), .div_cfg(div_cfg),
        .bright(bright), .busy(busy), .frame_done(frame_done), .sclk(sclk),
        .rclk(rclk), .dio(dio), .oe_n(oe_n));

    mfe_led7seg_74hc595_scan #(.SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut2 (
        .clk(clk), .rst(rst), .dat(dat2), .vld(vld2), .en(en2), .div_cfg(div_cfg2),
        .bright(bright2), .busy(busy2), .frame_done(frame_done2), .sclk(sclk2),
        .rclk(rclk2), .dio(dio2), .oe_n(oe_n2));

    // Pin monitor: shift register image built on sclk rises, pushed on rclk rise.
    logic [15:0] word_q[$];
    int lat_q[$], nb_q[$], fd_q[$];
    logic [15:0] m_sh;
    int m_nb;
    logic m_ps, m_pr;
    always @(negedge clk) begin
        if (!rst) begin
            m_sh = '0; m_nb = 0; m_ps = 1'b0; m_pr = 1'b0;
        end else begin
            if (sclk && !m_ps) begin m_sh = {m_sh[14:0], dio}; m_nb++; end
            if (rclk && !m_pr) begin
                word_q.push_back(m_sh); lat_q.push_back(cyc); nb_q.push_back(m_nb); m_nb = 0;
            end
            if (frame_done) fd_q.push_back(cyc);
            m_ps = sclk; m_pr = rclk;
        end
    end

    function automatic logic [15:0] exp_word(input logic [63:0] f, input int d,
                                             input bit sl, input bit dl);
        logic [7:0] s, p;
        s = f[8*d +: 8];
        p = 8'(1 << d);
        if (sl) s = ~s;
        if (dl) p = ~p;
        return {s, p};
    endfunction

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic clr_words();
        word_q.delete(); lat_q.delete(); nb_q.delete();
    endtask

    task automatic wait_word(output logic [15:0] w, output int t, output int nb);
        w = '0; t = 0; nb = 0;
        for (int i = 0; i < 1000; i++) begin
            if (word_q.size() > 0) break;
            step();
        end
        if (word_q.size() == 0) begin
            total++; bad++; $display("FAIL wait_word: no rclk within 1000 cycles");
        end else begin
            w = word_q.pop_front(); t = lat_q.pop_front(); nb = nb_q.pop_front();
        end
    endtask

    task automatic wait_fd(output int t);
        t = 0;
        for (int i = 0; i < 1000; i++) begin
            if (fd_q.size() > 0) break;
            step();
        end
        if (fd_q.size() == 0) begin
            total++; bad++; $display("FAIL wait_fd: no frame_done within 1000 cycles");
        end else t = fd_q.pop_front();
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; vld = 1'b0; dat = '0; div_cfg = 8'd0; bright = 4'd8;
        en2 = 1'b0; vld2 = 1'b0; dat2 = '0; div_cfg2 = 8'd0; bright2 = 4'd8;
        repeat (3) step();
        total++; if (sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk got=%b want=0", sclk); end
        total++; if (rclk !== 1'b0) begin bad++; $display("FAIL reset_rclk got=%b want=0", rclk); end
        total++; if (dio !== 1'b0) begin bad++; $display("FAIL reset_dio got=%b want=0", dio); end
        total++; if (oe_n !== 1'b1) begin bad++; $display("FAIL reset_oe_n got=%b want=1", oe_n); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b want=0", frame_done); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_first_digit();
        logic [15:0] w; int t0, t1, t2, nb, cnt;
        cur = 64'h0102030405060708;
        clr_words();
        dat = cur; vld = 1'b1; step(); vld = 1'b0; en = 1'b1;
        t0 = -1000;
        for (int i = 0; i < 10; i++) begin
            step();
            if (busy) begin t0 = cyc; break; end
        end
        wait_word(w, t1, nb);
        total++; if (w !== 16'h0801) begin bad++; $display("FAIL first_word got=%h want=0801", w); end
        total++; if (nb !== 16) begin bad++; $display("FAIL first_nbits got=%0d want=16", nb); end
        total++; if (t1 - t0 !== 33) begin bad++; $display("FAIL first_latch_delay got=%0d want=33", t1 - t0); end
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (oe_n === 1'b0) cnt++;
        end
        total++; if (cnt !== 8) begin bad++; $display("FAIL first_oe_low got=%0d want=8", cnt); end
        wait_word(w, t2, nb);
        total++; if (w !== exp_word(cur, 1, 0, 0)) begin bad++; $display("FAIL second_word got=%h want=%h", w, exp_word(cur, 1, 0, 0)); end
        total++; if (t2 - t1 !== 50) begin bad++; $display("FAIL digit_period got=%0d want=50", t2 - t1); end
    endtask

    task automatic test_full_frame();
        int f1, f2, f3, t, nb; logic [15:0] w;
        fd_q.delete();
        wait_fd(f1);
        clr_words();
        wait_fd(f2);
        total++; if (f2 - f1 !== 400) begin bad++; $display("FAIL frame_period1 got=%0d want=400", f2 - f1); end
        wait_fd(f3);
        total++; if (f3 - f2 !== 400) begin bad++; $display("FAIL frame_period2 got=%0d want=400", f3 - f2); end
        for (int i = 0; i < 9; i++) begin
            wait_word(w, t, nb);
            total++;
            if (w !== exp_word(cur, i % 8, 0, 0)) begin
                bad++; $display("FAIL frame_word%0d got=%h want=%h", i, w, exp_word(cur, i % 8, 0, 0));
            end
        end
    endtask

    task automatic test_vld_mid_frame();
        int f, t, nb; logic [15:0] w; logic [63:0] ones, r;
        ones = '1;
        fd_q.delete();
        wait_fd(f);
        clr_words();
        for (int i = 0; i < 4; i++) begin
            wait_word(w, t, nb);
            total++; if (w !== exp_word(cur, i, 0, 0)) begin bad++; $display("FAIL pre_vld_word%0d got=%h want=%h", i, w, exp_word(cur, i, 0, 0)); end
        end
        step(); dat = ones; vld = 1'b1; step(); vld = 1'b0;
        for (int i = 4; i < 8; i++) begin
            wait_word(w, t, nb);
            total++; if (w !== exp_word(cur, i, 0, 0)) begin bad++; $display("FAIL old_data_word%0d got=%h want=%h", i, w, exp_word(cur, i, 0, 0)); end
        end
        wait_word(w, t, nb);
        total++; if (w !== exp_word(ones, 0, 0, 0)) begin bad++; $display("FAIL new_data_word0 got=%h want=%h", w, exp_word(ones, 0, 0, 0)); end
        cur = ones;
        fd_q.delete();
        wait_fd(f);
        clr_words();
        step();
        r = {$urandom, $urandom} & ~64'h1;
        dat = r; vld = 1'b1; step(); vld = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wait_word(w, t, nb);
            total++; if (w !== exp_word(r, i, 0, 0)) begin bad++; $display("FAIL load_vld_word%0d got=%h want=%h", i, w, exp_word(r, i, 0, 0)); end
        end
        cur = r;
    endtask

    task automatic test_polarity();
        logic [63:0] p; logic [15:0] sh; int nb, oe_bad; logic ps, pr, done;
        p = {$urandom, $urandom}; p[7:0] = 8'h3F;
        dat2 = p; vld2 = 1'b1; step(); vld2 = 1'b0; en2 = 1'b1;
        sh = '0; nb = 0; oe_bad = 0; done = 1'b0; ps = sclk2; pr = rclk2;
        for (int i = 0; i < 200; i++) begin
            step();
            if (sclk2 && !ps) begin sh = {sh[14:0], dio2}; nb++; end
            if (sclk2 && oe_n2 !== 1'b1) oe_bad++;
            if (rclk2 && !pr) begin done = 1'b1; break; end
            ps = sclk2; pr = rclk2;
        end
        en2 = 1'b0;
        total++; if (!done || sh !== exp_word(p, 0, 1, 1)) begin bad++; $display("FAIL polarity_word got=%h want=%h", sh, exp_word(p, 0, 1, 1)); end
        total++; if (nb !== 16) begin bad++; $display("FAIL polarity_nbits got=%0d want=16", nb); end
        total++; if (oe_bad !== 0) begin bad++; $display("FAIL polarity_oe_during_shift got=%0d want=0", oe_bad); end
    endtask

    task automatic test_div_bright();
        logic [15:0] w; int t1, nb, nl, run, lr, rises, hi_bad, sp_bad;
        int oe_lo[2], lt[2]; logic ps, pr;
        clr_words();
        wait_word(w, t1, nb);
        step();
        div_cfg = 8'd3; bright = 4'd0;
        oe_lo[0] = (oe_n === 1'b0) ? 1 : 0; oe_lo[1] = 0; lt[0] = 0; lt[1] = 0;
        nl = 0; run = 0; lr = -1; rises = 0; hi_bad = 0; sp_bad = 0; ps = sclk; pr = rclk;
        for (int i = 0; i < 800; i++) begin
            step();
            if (oe_n === 1'b0) oe_lo[nl]++;
            if (nl == 0) begin
                if (sclk && !ps) begin
                    rises++;
                    if (lr >= 0 && cyc - lr != 8) sp_bad++;
                    lr = cyc;
                end
                if (sclk) run++;
                if (!sclk && ps) begin
                    if (run != 4) hi_bad++;
                    run = 0;
                end
            end
            if (rclk && !pr) begin lt[nl] = cyc; nl++; end
            ps = sclk; pr = rclk;
            if (nl == 2) break;
        end
        total++; if (lt[0] - t1 !== 146) begin bad++; $display("FAIL div_change_latch got=%0d want=146", lt[0] - t1); end
        total++; if (lt[1] - lt[0] !== 197) begin bad++; $display("FAIL div3_period got=%0d want=197", lt[1] - lt[0]); end
        total++; if (oe_lo[0] !== 8) begin bad++; $display("FAIL old_bright_oe got=%0d want=8", oe_lo[0]); end
        total++; if (oe_lo[1] !== 0) begin bad++; $display("FAIL bright0_oe got=%0d want=0", oe_lo[1]); end
        total++; if (rises !== 16) begin bad++; $display("FAIL div3_rises got=%0d want=16", rises); end
        total++; if (hi_bad !== 0 || sp_bad !== 0) begin bad++; $display("FAIL div3_sclk_phase got=%0d/%0d want=0/0", hi_bad, sp_bad); end
    endtask

    task automatic test_random_bright();
        logic [15:0] w; int ta, tb, nb, cnt, b, d; logic pr;
        for (int it = 0; it < 3; it++) begin
            b = $urandom_range(1, 15); d = $urandom_range(0, 2);
            clr_words();
            div_cfg = 8'(d); bright = 4'(b);
            wait_word(w, ta, nb);
            wait_word(w, ta, nb);
            cnt = 0; tb = ta; pr = rclk;
            for (int i = 0; i < 800; i++) begin
                step();
                if (oe_n === 1'b0) cnt++;
                if (rclk && !pr) begin tb = cyc; break; end
                pr = rclk;
            end
            total++; if (cnt !== b * (d + 1)) begin bad++; $display("FAIL rand_oe b=%0d d=%0d got=%0d want=%0d", b, d, cnt, b * (d + 1)); end
            total++; if (tb - ta !== 1 + 49 * (d + 1)) begin bad++; $display("FAIL rand_period d=%0d got=%0d want=%0d", d, tb - ta, 1 + 49 * (d + 1)); end
        end
    endtask

    task automatic test_en_off();
        logic [15:0] w; int t, nb, idx, cnt, viol; logic b16, b17;
        div_cfg = 8'd0; bright = 4'd8;
        clr_words();
        wait_word(w, t, nb);
        wait_word(w, t, nb);
        idx = 0;
        for (int k = 0; k < 8; k++) if (w[k]) idx = k;
        cnt = 0; b16 = 1'b0; b17 = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            if (oe_n === 1'b0) cnt++;
            if (k == 3) en = 1'b0;
            if (k == 16) b16 = busy;
            if (k == 17) b17 = busy;
        end
        total++; if (cnt !== 8) begin bad++; $display("FAIL en_off_dwell_oe got=%0d want=8", cnt); end
        total++; if (b16 !== 1'b1 || b17 !== 1'b0) begin bad++; $display("FAIL en_off_busy_edge got=%b%b want=10", b16, b17); end
        viol = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (busy !== 1'b0 || oe_n !== 1'b1 || sclk !== 1'b0 || rclk !== 1'b0) viol++;
        end
        total++; if (viol !== 0) begin bad++; $display("FAIL en_off_idle got=%0d want=0", viol); end
        clr_words();
        en = 1'b1;
        wait_word(w, t, nb);
        total++; if (w !== exp_word(cur, (idx + 1) % 8, 0, 0)) begin bad++; $display("FAIL resume_word got=%h want=%h", w, exp_word(cur, (idx + 1) % 8, 0, 0)); end
    endtask

    task automatic test_async_reset();
        logic [15:0] w; int t, nb; logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (sclk) begin seen = 1'b1; break; end
        end
        total++; if (!seen) begin bad++; $display("FAIL async_find_shift got=0 want=1"); end
        #2 rst = 1'b0;
        #1;
        total++; if (sclk !== 1'b0 || rclk !== 1'b0 || dio !== 1'b0) begin bad++; $display("FAIL async_shift_pins got=%b%b%b want=000", sclk, rclk, dio); end
        total++; if (oe_n !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin bad++; $display("FAIL async_ctrl got=%b%b%b want=100", oe_n, busy, frame_done); end
        step();
        rst = 1'b1;
        clr_words();
        wait_word(w, t, nb);
        total++; if (w !== exp_word(64'h0, 0, 0, 0)) begin bad++; $display("FAIL post_reset_word got=%h want=%h", w, exp_word(64'h0, 0, 0, 0)); end
    endtask

    initial begin
        test_reset();
        test_first_digit();
        test_full_frame();
        test_vld_mid_frame();
        test_polarity();
        test_div_bright();
        test_random_bright();
        test_en_off();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
